// File: rtl/hilo_mult_ctrl.sv
// Sequencing controller for the shared 32x32 unsigned multiplier and the HI/LO pair.
// Define MULT_ACC_EN to enable MADD/MADDU accumulation into {HI,LO}.
module hilo_mult_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
`ifdef MULT_ACC_EN
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
`endif

    localparam logic [3:0] LAST_CNT = 4'(MUL_LAT - 1);

    // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [63:0] z_s;
    logic [63:0] result_s;
`ifdef MULT_ACC_EN
    logic        acc_q, acc_d;
`endif

    // Sign fix-up of the unsigned product, optionally accumulated onto {HI,LO}.
    always_comb begin
        z_s = neg_q ? (~mul_z + 64'd1) : mul_z;
`ifdef MULT_ACC_EN
        if (acc_q) begin
            result_s = {hi_q, lo_q} + z_s;
        end else begin
            result_s = z_s;
        end
`else
        result_s = z_s;
`endif
    end

    // Next-state logic for the IDLE/WAIT sequencer and HI/LO writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULT_ACC_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT: begin
                            mul_a_d = magnitude(rs_val);
                            mul_b_d = magnitude(rt_val);
                            neg_d   = rs_val[31] ^ rt_val[31];
                            cnt_d   = 4'd0;
                            state_d = ST_WAIT;
`ifdef MULT_ACC_EN
                            acc_d   = 1'b0;
`endif
                        end
                        OP_MULTU: begin
                            mul_a_d = rs_val;
                            mul_b_d = rt_val;
                            neg_d   = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = ST_WAIT;
`ifdef MULT_ACC_EN
                            acc_d   = 1'b0;
`endif
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
`ifdef MULT_ACC_EN
                        OP_MADD: begin
                            mul_a_d = magnitude(rs_val);
                            mul_b_d = magnitude(rt_val);
                            neg_d   = rs_val[31] ^ rt_val[31];
                            cnt_d   = 4'd0;
                            acc_d   = 1'b1;
                            state_d = ST_WAIT;
                        end
                        OP_MADDU: begin
                            mul_a_d = rs_val;
                            mul_b_d = rt_val;
                            neg_d   = 1'b0;
                            cnt_d   = 4'd0;
                            acc_d   = 1'b1;
                            state_d = ST_WAIT;
                        end
`endif
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A flush wins even on the final edge, so no partial write escapes.
                if (cancel) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    hi_d    = result_s[63:32];
                    lo_d    = result_s[31:0];
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_WAIT);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            neg_q   <= 1'b0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULT_ACC_EN
            acc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULT_ACC_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed, table-driven bench for hilo_mult_ctrl with a behavioural multiplier.
module tb_hilo_mult_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[7];

    hilo_mult_ctrl #(.MUL_LAT(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .cancel (cancel),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_z  (mul_z),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    assign mul_z = {32'd0, mul_a} * {32'd0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Steps while busy is high, bounded; returns number of busy cycles seen.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; cancel = 1'b0;
        op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;

        vecs[0] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'h00000003, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{3'b000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{3'b000, 32'h00000005, 32'hFFFFFFFE, 32'h00000005, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFF6};
        vecs[4] = '{3'b000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000};
        vecs[5] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001};
        vecs[6] = '{3'b001, 32'h12345678, 32'h00000010, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        step();
        step();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
            chk($sformatf("v%0d_busy_issue", i), busy, 1'b1);
            chk($sformatf("v%0d_done_issue", i), done, 1'b0);
            chk($sformatf("v%0d_mul_a", i), mul_a, vecs[i].ea);
            chk($sformatf("v%0d_mul_b", i), mul_b, vecs[i].eb);
            wait_idle(n);
            chk($sformatf("v%0d_busy_cycles", i), n, LAT);
            chk($sformatf("v%0d_done", i), done, 1'b1);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].elo);
            chk($sformatf("v%0d_busy_end", i), busy, 1'b0);
            step();
            chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
        end

        // Reset asserted mid-WAIT for two edges.
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_mul_a", mul_a, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("midrst_no_done%0d", k), done, 1'b0);
        end

        // MTHI then MTLO on consecutive cycles.
        op = 3'b010; rs_val = 32'h12345678; start = 1'b1;
        step();
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", busy, 1'b0);
        chk("mthi_done", done, 1'b0);
        op = 3'b011; rs_val = 32'h9ABCDEF0;
        step();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi", hi, 32'h12345678);
        chk("mtlo_busy", busy, 1'b0);
        chk("mtlo_done", done, 1'b0);

        // Cancel on the second WAIT cycle; a start while busy is ignored.
        issue(3'b000, 32'hFFFFFFFD, 32'h00000003);
        chk("cx_mul_a", mul_a, 32'h3);
        op = 3'b001; rs_val = 32'hAAAAAAAA; rt_val = 32'h5; start = 1'b1;
        step();
        start = 1'b0;
        chk("cx_mul_a_held", mul_a, 32'h3);
        chk("cx_mul_b_held", mul_b, 32'h3);
        chk("cx_busy_held", busy, 1'b1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cx_busy_drop", busy, 1'b0);
        chk("cx_done", done, 1'b0);
        chk("cx_hi", hi, 32'h12345678);
        chk("cx_lo", lo, 32'h9ABCDEF0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("cx_no_done%0d", k), done, 1'b0);
            chk($sformatf("cx_busy%0d", k), busy, 1'b0);
        end

        // start with cancel in IDLE is ignored.
        op = 3'b010; rs_val = 32'hDEADBEEF; start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        chk("idlecx_hi", hi, 32'h12345678);
        chk("idlecx_busy", busy, 1'b0);

        // Unused opcode is a no-op.
        issue(3'b111, 32'h11111111, 32'h22222222);
        chk("nop_busy", busy, 1'b0);
        chk("nop_hi", hi, 32'h12345678);
        chk("nop_lo", lo, 32'h9ABCDEF0);

        // Back-to-back issue in the done cycle, then MTLO in the next done cycle.
        issue(3'b001, 32'd2, 32'd3);
        wait_idle(n);
        chk("b2b_done1", done, 1'b1);
        chk("b2b_lo1", lo, 32'd6);
        issue(3'b001, 32'd4, 32'd5);
        chk("b2b_busy2", busy, 1'b1);
        wait_idle(n);
        chk("b2b_cycles2", n, LAT);
        chk("b2b_done2", done, 1'b1);
        chk("b2b_lo2", lo, 32'd20);
        issue(3'b011, 32'h55, 32'd0);
        chk("b2b_mtlo", lo, 32'h55);
        chk("b2b_hi", hi, 32'd0);

        // MADDU: accumulates with the macro, no-op without it.
        issue(3'b010, 32'h0, 32'd0);
        issue(3'b011, 32'hFFFFFFFF, 32'd0);
        issue(3'b101, 32'd1, 32'd1);
`ifdef MULT_ACC_EN
        chk("maddu_busy", busy, 1'b1);
        wait_idle(n);
        chk("maddu_done", done, 1'b1);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
`else
        chk("maddu_busy", busy, 1'b0);
        step();
        step();
        chk("maddu_done", done, 1'b0);
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
